// File: rtl/handshaked_fifo.sv
// handshaked_fifo: first-word-fall-through FIFO with valid/ready style handshakes.
// Circular buffer of DEPTH words addressed by write/read pointers, plus an
// occupancy counter that drives both flow-control flags from registers only.
// Optional build macro HANDSHAKED_FIFO_SIZE_EN exposes the occupancy on `size`.
module handshaked_fifo #(
  parameter int DATA_WIDTH = 2,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] dataIn_data,
  input  logic                  dataIn_vld,
  output logic                  dataIn_rd,
  output logic [DATA_WIDTH-1:0] dataOut_data,
  output logic                  dataOut_vld,
  input  logic                  dataOut_rd
`ifdef HANDSHAKED_FIFO_SIZE_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] size
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  push;
  logic                  pop;

  // Flags come straight from the counter, so neither ready depends on the other side.
  assign dataIn_rd    = (cnt_q != CNT_W'(DEPTH));
  assign dataOut_vld  = (cnt_q != '0);
  assign dataOut_data = mem_q[rd_ptr_q];
  assign push         = dataIn_vld & dataIn_rd;
  assign pop          = dataOut_vld & dataOut_rd;

`ifdef HANDSHAKED_FIFO_SIZE_EN
  assign size = cnt_q;
`endif

  // Next-state for pointers and occupancy; pointers wrap naturally (DEPTH is a power of two).
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Control registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage write on an accepted word; suppressed while reset is asserted.
  always_ff @(posedge clk) begin
    // NOTE: storage is deliberately not reset; dataOut_vld masks stale contents.
    if (rst_n && push) mem_q[wr_ptr_q] <= dataIn_data;
  end

endmodule

// File: tb/tb_handshaked_fifo.sv
// tb_handshaked_fifo: directed plus randomized stimulus against a queue-based
// reference model of the FIFO (DATA_WIDTH=3, DEPTH=4).
module tb_handshaked_fifo;

  localparam int DW    = 3;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] dataIn_data = '0;
  logic          dataIn_vld = 1'b0;
  logic          dataIn_rd;
  logic [DW-1:0] dataOut_data;
  logic          dataOut_vld;
  logic          dataOut_rd = 1'b0;
`ifdef HANDSHAKED_FIFO_SIZE_EN
  logic [2:0]    size;
`endif

  handshaked_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .dataIn_data  (dataIn_data),
    .dataIn_vld   (dataIn_vld),
    .dataIn_rd    (dataIn_rd),
    .dataOut_data (dataOut_data),
    .dataOut_vld  (dataOut_vld),
    .dataOut_rd   (dataOut_rd)
`ifdef HANDSHAKED_FIFO_SIZE_EN
    ,
    .size         (size)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: the FIFO contents as a queue.
  logic [DW-1:0] model_q [$];
  bit            model_ok = 1'b0;
  bit            did_push;
  bit            did_pop;
  logic [DW-1:0] popped_val;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle: compare outputs with the model, clock, then advance the model.
  task automatic tick(input logic rst, input logic vld, input logic [DW-1:0] data, input logic rd);
    rst_n       = rst;
    dataIn_vld  = vld;
    dataIn_data = data;
    dataOut_rd  = rd;
    if (model_ok) begin
      check("in_rd", dataIn_rd, model_q.size() != DEPTH);
      check("out_vld", dataOut_vld, model_q.size() != 0);
      if (model_q.size() != 0) check("out_data", dataOut_data, model_q[0]);
`ifdef HANDSHAKED_FIFO_SIZE_EN
      check("size", size, model_q.size());
`endif
    end
    did_push   = rst && vld && (model_q.size() < DEPTH);
    did_pop    = rst && rd && (model_q.size() > 0);
    popped_val = dataOut_data;
    @(posedge clk);
    #1;
    if (!rst) begin
      model_q.delete();
      model_ok = 1'b1;
    end else begin
      if (did_pop)  void'(model_q.pop_front());
      if (did_push) model_q.push_back(data);
    end
  endtask

  initial begin
    int in_idx;
    int out_idx;
    int cycles;

    // Reset
    tick(1'b0, 1'b0, '0, 1'b0);
    tick(1'b0, 1'b1, 3'h2, 1'b1);
    check("reset_in_rd", dataIn_rd, 1);
    check("reset_out_vld", dataOut_vld, 0);

    // Single word
    tick(1'b1, 1'b1, 3'h5, 1'b0);
    check("single_vld", dataOut_vld, 1);
    check("single_data", dataOut_data, 3'h5);
`ifdef HANDSHAKED_FIFO_SIZE_EN
    check("single_size", size, 1);
`endif
    tick(1'b1, 1'b0, '0, 1'b1);
    check("single_empty", dataOut_vld, 0);

    // Fill, overflow attempt, drain
    for (int i = 1; i <= 4; i++) tick(1'b1, 1'b1, DW'(i), 1'b0);
    check("fill_full", dataIn_rd, 0);
    tick(1'b1, 1'b1, 3'h7, 1'b0);
    check("fill_hold", dataIn_rd, 0);
`ifdef HANDSHAKED_FIFO_SIZE_EN
    check("fill_size", size, 4);
`endif
    for (int i = 1; i <= 4; i++) begin
      check("drain_data", dataOut_data, i);
      tick(1'b1, 1'b0, '0, 1'b1);
    end
    check("drain_empty", dataOut_vld, 0);

    // Simultaneous push and pop at occupancy 2
    tick(1'b1, 1'b1, 3'h1, 1'b0);
    tick(1'b1, 1'b1, 3'h2, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick(1'b1, 1'b1, DW'(i + 3), 1'b1);
      check("sim_vld", dataOut_vld, 1);
      check("sim_in_rd", dataIn_rd, 1);
    end

    // Full with concurrent offer and pop: only the pop happens
    tick(1'b1, 1'b1, 3'h6, 1'b0);
    tick(1'b1, 1'b1, 3'h7, 1'b0);
    check("full_before", dataIn_rd, 0);
    tick(1'b1, 1'b1, 3'h3, 1'b1);
    check("full_pop_rd", dataIn_rd, 1);
`ifdef HANDSHAKED_FIFO_SIZE_EN
    check("full_pop_size", size, 3);
`endif
    while (model_q.size() != 0) tick(1'b1, 1'b0, '0, 1'b1);

    // Wrap-around stream of 0..7 repeating, 20 words, random handshakes
    in_idx  = 0;
    out_idx = 0;
    cycles  = 0;
    while (out_idx < 20 && cycles < 500) begin
      tick(1'b1, (in_idx < 20) ? 1'($urandom_range(0, 1)) : 1'b0, DW'(in_idx % 8),
           1'($urandom_range(0, 1)));
      if (did_push) in_idx++;
      if (did_pop) begin
        check("wrap_order", popped_val, out_idx % 8);
        out_idx++;
      end
      cycles++;
    end
    check("wrap_count", out_idx, 20);
    check("wrap_empty", dataOut_vld, 0);

    // Mid-stream reset at occupancy 3
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, DW'(i + 1), 1'b0);
    tick(1'b0, 1'b1, 3'h5, 1'b1);
    check("mrst_vld", dataOut_vld, 0);
    check("mrst_in_rd", dataIn_rd, 1);
`ifdef HANDSHAKED_FIFO_SIZE_EN
    check("mrst_size", size, 0);
`endif
    tick(1'b1, 1'b1, 3'h6, 1'b0);
    check("mrst_first", dataOut_data, 3'h6);
    tick(1'b1, 1'b0, '0, 1'b1);

    // Random soak with occasional resets
    for (int i = 0; i < 200; i++) begin
      tick(1'($urandom_range(0, 24) != 0), 1'($urandom_range(0, 1)),
           DW'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
